// File: rtl/d5m_emu_pkg.sv
// Shared definitions for the D5M stream emulator: FSM states, pattern codes,
// and the noise-LFSR constants used when D5M_EMU_LFSR_NOISE_EN is defined.
package d5m_emu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEAD   = 3'd1,
    S_ACTIVE = 3'd2,
    S_HBLANK = 3'd3,
    S_TRAIL  = 3'd4,
    S_VBLANK = 3'd5
  } state_t;

  localparam logic [1:0] PAT_RAMP  = 2'b00;
  localparam logic [1:0] PAT_BARS  = 2'b01;
  localparam logic [1:0] PAT_CHECK = 2'b10;
  localparam logic [1:0] PAT_CONST = 2'b11;

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/d5m_pattern_gen.sv
// Combinational test-pattern pixel generator: pixel value for (x, y) of
// frame f under the selected pattern. No state; the top registers the result.
module d5m_pattern_gen
  import d5m_emu_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280
) (
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [11:0] frame_lsb,
  input  logic [1:0]  pattern,
  input  logic [11:0] const_val,
  output logic [11:0] pixel
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0] colour;
  logic       site_on;

  // Bar colour (R,G,B = bits 2,1,0) and whether this Bayer site's colour is lit
  always_comb begin
    colour  = 3'(12'd7 - (x / 12'(BAR_W)));
    site_on = 1'b0;
    unique case ({y[0], x[0]})
      2'b00, 2'b11: site_on = colour[1];
      2'b01:        site_on = colour[2];
      2'b10:        site_on = colour[0];
      default:      site_on = 1'b0;
    endcase
  end

  // Pattern select
  always_comb begin
    pixel = '0;
    unique case (pattern)
      PAT_RAMP:  pixel = x + y + frame_lsb;
      PAT_BARS:  pixel = site_on ? '1 : '0;
      PAT_CHECK: pixel = (x[4] ^ y[4]) ? '1 : '0;
      PAT_CONST: pixel = const_val;
      default:   pixel = '0;
    endcase
  end

endmodule

// File: rtl/d5m_stream_emulator.sv
// Synthetic D5M sensor source: FVAL/LVAL/12-bit Bayer stream from an internal
// pattern generator. Optional feature macro: D5M_EMU_LFSR_NOISE_EN (XORs a
// 16-bit LFSR's low nibble into oD[3:0] of every active pixel).
module d5m_stream_emulator
  import d5m_emu_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_BLANK  = 64,
  parameter int unsigned V_ACTIVE = 960,
  parameter int unsigned FV_LEAD  = 16,
  parameter int unsigned FV_TRAIL = 16,
  parameter int unsigned V_BLANK  = 1024
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEN,
  input  logic [1:0]  iPATTERN,
  input  logic [11:0] iCONST,
  output logic [11:0] oD,
  output logic        oFVAL,
  output logic        oLVAL,
  output logic [15:0] oFRAME_CNT,
  output logic        oBUSY
);

  localparam logic [11:0] X_LAST     = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_LAST     = 12'(V_ACTIVE - 1);
  localparam logic [15:0] LEAD_LAST  = 16'(FV_LEAD - 1);
  localparam logic [15:0] HB_LAST    = 16'(H_BLANK - 1);
  localparam logic [15:0] TRAIL_LAST = 16'(FV_TRAIL - 1);
  localparam logic [15:0] VB_LAST    = 16'(V_BLANK - 1);

  state_t      state, state_nx;
  logic [11:0] x, x_nx;
  logic [11:0] y, y_nx;
  logic [15:0] phase, phase_nx;
  logic        frame_done;
  logic [1:0]  pat_q;
  logic [11:0] const_q;
  logic [11:0] pix;
  logic [11:0] pix_out;

  // Next-state and next-coordinate logic. The output registers are loaded
  // from these next values so that state, FVAL, LVAL and pixel data all
  // change on the same edge with zero relative latency.
  always_comb begin
    state_nx   = state;
    x_nx       = x;
    y_nx       = y;
    phase_nx   = phase + 16'd1;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        phase_nx = '0;
        if (iEN) state_nx = S_LEAD;
      end
      S_LEAD: begin
        if (phase == LEAD_LAST) begin
          state_nx = S_ACTIVE;
          phase_nx = '0;
          x_nx     = '0;
          y_nx     = '0;
        end
      end
      S_ACTIVE: begin
        phase_nx = '0;
        if (x == X_LAST) state_nx = (y == Y_LAST) ? S_TRAIL : S_HBLANK;
        else             x_nx     = x + 12'd1;
      end
      S_HBLANK: begin
        if (phase == HB_LAST) begin
          state_nx = S_ACTIVE;
          phase_nx = '0;
          x_nx     = '0;
          y_nx     = y + 12'd1;
        end
      end
      S_TRAIL: begin
        if (phase == TRAIL_LAST) begin
          state_nx   = S_VBLANK;
          phase_nx   = '0;
          frame_done = 1'b1;
        end
      end
      S_VBLANK: begin
        if (phase == VB_LAST) begin
          state_nx = iEN ? S_LEAD : S_IDLE;
          phase_nx = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        phase_nx = '0;
      end
    endcase
  end

  d5m_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern_gen (
    .x         (x_nx),
    .y         (y_nx),
    .frame_lsb (oFRAME_CNT[11:0]),
    .pattern   (pat_q),
    .const_val (const_q),
    .pixel     (pix)
  );

`ifdef D5M_EMU_LFSR_NOISE_EN
  logic [15:0] lfsr;

  // Noise LFSR, stepped once for every pixel placed on the bus
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)                       lfsr <= LFSR_SEED;
    else if (state_nx == S_ACTIVE)  lfsr <= lfsr_step(lfsr);
  end

  assign pix_out = pix ^ {8'h00, lfsr[3:0]};
`else
  assign pix_out = pix;
`endif

  // Timing state, counters, latched frame settings and registered outputs
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      phase      <= '0;
      pat_q      <= PAT_RAMP;
      const_q    <= '0;
      oD         <= '0;
      oFVAL      <= 1'b0;
      oLVAL      <= 1'b0;
      oFRAME_CNT <= '0;
    end else begin
      state <= state_nx;
      x     <= x_nx;
      y     <= y_nx;
      phase <= phase_nx;
      if (state_nx == S_LEAD && state != S_LEAD) begin
        pat_q   <= iPATTERN;
        const_q <= iCONST;
      end
      oFVAL <= (state_nx == S_LEAD)   || (state_nx == S_ACTIVE) ||
               (state_nx == S_HBLANK) || (state_nx == S_TRAIL);
      oLVAL <= (state_nx == S_ACTIVE);
      oD    <= (state_nx == S_ACTIVE) ? pix_out : '0;
      if (frame_done) oFRAME_CNT <= oFRAME_CNT + 16'd1;
    end
  end

  assign oBUSY = (state != S_IDLE);

endmodule

// File: tb/tb_d5m_stream_emulator.sv
// Directed bench for d5m_stream_emulator with a 16x4 frame geometry.
module tb_d5m_stream_emulator;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iEN = 1'b0;
  logic [1:0]  iPATTERN = 2'b00;
  logic [11:0] iCONST = 12'h000;
  logic [11:0] oD;
  logic        oFVAL;
  logic        oLVAL;
  logic [15:0] oFRAME_CNT;
  logic        oBUSY;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;

  always #5 iCLK = ~iCLK;

  d5m_stream_emulator #(
    .H_ACTIVE (16),
    .H_BLANK  (4),
    .V_ACTIVE (4),
    .FV_LEAD  (3),
    .FV_TRAIL (2),
    .V_BLANK  (5)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iEN        (iEN),
    .iPATTERN   (iPATTERN),
    .iCONST     (iCONST),
    .oD         (oD),
    .oFVAL      (oFVAL),
    .oLVAL      (oLVAL),
    .oFRAME_CNT (oFRAME_CNT),
    .oBUSY      (oBUSY)
  );

  // advance to the falling edge following rising edge k (counted from release)
  task automatic go_to(input int k);
    while (cyc < k) begin
      @(negedge iCLK);
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  int unsigned lv_hi, lv_rise, fv_hi, bad, n_px;
  logic        lv_prev;

  initial begin
    // reset state
    repeat (3) @(negedge iCLK);
    chk("rst_d", 32'(oD), 0);
    chk("rst_fval", 32'(oFVAL), 0);
    chk("rst_lval", 32'(oLVAL), 0);
    chk("rst_cnt", 32'(oFRAME_CNT), 0);
    chk("rst_busy", 32'(oBUSY), 0);

    // frame 0, ramp, iEN held high
    iRST = 1'b0;
    iEN = 1'b1;
    iPATTERN = 2'b00;
    cyc = 0;
    lv_hi = 0; lv_rise = 0; fv_hi = 0; lv_prev = 1'b0;
    for (int k = 1; k <= 86; k++) begin
      go_to(k);
      if (oLVAL) lv_hi++;
      if (oLVAL && !lv_prev) lv_rise++;
      lv_prev = oLVAL;
      if (oFVAL) fv_hi++;
      case (k)
        1:  begin chk("f0_fval_rise", 32'(oFVAL), 1); chk("f0_lval_lead", 32'(oLVAL), 0);
                  chk("f0_busy", 32'(oBUSY), 1); chk("f0_d_lead", 32'(oD), 0); end
        3:  chk("f0_lval_lead3", 32'(oLVAL), 0);
        4:  begin chk("f0_lval_first", 32'(oLVAL), 1); chk("ramp_x0y0", 32'(oD), 0); end
        5:  chk("ramp_x1y0", 32'(oD), 1);
        20: begin chk("hb_lval", 32'(oLVAL), 0); chk("hb_d", 32'(oD), 0); chk("hb_fval", 32'(oFVAL), 1); end
        23: chk("hb_last_lval", 32'(oLVAL), 0);
        24: chk("line1_lval", 32'(oLVAL), 1);
        27: chk("ramp_f0_y1x3", 32'(oD), 4);
        81: begin chk("trail_fval", 32'(oFVAL), 1); chk("trail_cnt", 32'(oFRAME_CNT), 0); end
        82: begin chk("vb_fval", 32'(oFVAL), 0); chk("vb_cnt", 32'(oFRAME_CNT), 1); chk("vb_busy", 32'(oBUSY), 1); end
        86: chk("vb_end_fval", 32'(oFVAL), 0);
        default: ;
      endcase
    end
    chk("f0_lval_cycles", lv_hi, 64);
    chk("f0_lval_pulses", lv_rise, 4);
    chk("f0_fval_cycles", fv_hi, 81);

    go_to(87);  chk("f1_fval_period", 32'(oFVAL), 1);
    go_to(167); chk("f1_trail_cnt", 32'(oFRAME_CNT), 1);
    go_to(168); chk("f1_end_cnt", 32'(oFRAME_CNT), 2); chk("f1_end_fval", 32'(oFVAL), 0);
    go_to(199); chk("ramp_f2_y1x3", 32'(oD), 6);

    // bars in frame 3 (starts edge 259, first pixel edge 262)
    go_to(200); iPATTERN = 2'b01;
    go_to(262); chk("bars_x0", 32'(oD), 32'hFFF);
    go_to(263); chk("bars_x1", 32'(oD), 32'hFFF);
    go_to(268); chk("bars_x6", 32'(oD), 32'h000);
    go_to(269); chk("bars_x7", 32'(oD), 32'hFFF);
    go_to(276); chk("bars_x14", 32'(oD), 32'h000);

    // checker in frame 4, switched to constant mid-frame
    go_to(300); iPATTERN = 2'b10;
    go_to(359); iPATTERN = 2'b11; iCONST = 12'h5A5;
    bad = 0;
    for (int k = 360; k <= 430; k++) begin
      go_to(k);
      if (oD !== 12'h000) bad++;
    end
    chk("checker_rest_of_frame", bad, 0);

    // frame 5 entirely constant, iCONST change mid-frame ignored
    bad = 0; n_px = 0;
    for (int k = 431; k <= 516; k++) begin
      go_to(k);
      if (k == 470) iCONST = 12'h123;
      if (oLVAL) begin
        n_px++;
        if (oD !== 12'h5A5) bad++;
      end else if (oD !== 12'h000) bad++;
    end
    chk("const_frame_bad", bad, 0);
    chk("const_frame_pixels", n_px, 64);

    // iEN dropped at y=1 of frame 6
    go_to(545); chk("drop_in_line1", 32'(oLVAL), 1);
    iEN = 1'b0;
    go_to(597); chk("drop_trail_fval", 32'(oFVAL), 1); chk("drop_cnt_before", 32'(oFRAME_CNT), 6);
    go_to(598); chk("drop_fval_fall", 32'(oFVAL), 0); chk("drop_cnt_after", 32'(oFRAME_CNT), 7);
    go_to(602); chk("drop_vb_busy", 32'(oBUSY), 1);
    go_to(603); chk("drop_idle_busy", 32'(oBUSY), 0);
    bad = 0;
    for (int k = 604; k <= 800; k++) begin
      go_to(k);
      if (oFVAL || oBUSY || oFRAME_CNT != 16'd7) bad++;
    end
    chk("idle_stays_quiet", bad, 0);

    // reset pulsed mid-ACTIVE
    iPATTERN = 2'b00;
    go_to(810); iEN = 1'b1;
    go_to(819); chk("pre_rst_lval", 32'(oLVAL), 1); chk("pre_rst_ramp", 32'(oD), 12);
    iRST = 1'b1;
    #1;
    chk("async_rst_d", 32'(oD), 0);
    chk("async_rst_fval", 32'(oFVAL), 0);
    chk("async_rst_lval", 32'(oLVAL), 0);
    chk("async_rst_cnt", 32'(oFRAME_CNT), 0);
    chk("async_rst_busy", 32'(oBUSY), 0);
    go_to(822); chk("rst_hold_fval", 32'(oFVAL), 0);
    iRST = 1'b0;
    cyc = 0;
    go_to(1);  chk("post_rst_fval", 32'(oFVAL), 1); chk("post_rst_lval", 32'(oLVAL), 0);
    go_to(3);  chk("post_rst_lead3", 32'(oLVAL), 0);
    go_to(4);  chk("post_rst_lval4", 32'(oLVAL), 1); chk("post_rst_x0", 32'(oD), 0);
    go_to(5);  chk("post_rst_x1", 32'(oD), 1);
    go_to(24); chk("post_rst_y1x0", 32'(oD), 1);
    go_to(82); chk("post_rst_cnt", 32'(oFRAME_CNT), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
